// File: rtl/router_pkg.sv
// router_pkg: definitions shared across the 5-port mesh router.
//   flit_id_e  - flit type codes carried with every flit
//   port_oh_e  - one-hot port encodings, matching the arbiter's state bits
//   req_state_e - per-port requester FSM states
//   LEN_W      - width of the packet length field in a header flit
package router_pkg;

  localparam int LEN_W = 12;

  typedef enum logic [2:0] {
    FLIT_NONE = 3'b000,
    HEADER    = 3'b001,
    BODY      = 3'b010,
    TAIL      = 3'b100
  } flit_id_e;

  typedef enum logic [4:0] {
    PORT_L = 5'b00001,
    PORT_N = 5'b00010,
    PORT_E = 5'b00100,
    PORT_W = 5'b01000,
    PORT_S = 5'b10000
  } port_oh_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SEND,
    SUSPEND
  } req_state_e;

endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: synchronous circular FIFO with wrap-bit pointers.
//   clk, rst        - clock, synchronous active-high reset (pointers only)
//   push_i, wdata_i - write request and data; taken when not full, or when
//                     full and popping in the same cycle
//   pop_i           - read request; ignored when empty
//   full_o, empty_o - occupancy flags derived from the pointers
//   head_o          - entry at the read pointer (meaningless when empty)
module flit_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // When full, the write slot is the slot being read this cycle, so a
  // simultaneous push and pop keeps the occupancy unchanged.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign wptr_d  = do_push ? wptr_q + (AW + 1)'(1) : wptr_q;
  assign rptr_d  = do_pop  ? rptr_q + (AW + 1)'(1) : rptr_q;

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/port_requester.sv
// port_requester: input-side requester for one router port. Buffers flits,
// decodes the head flit for the output arbiter and drains one flit per cycle
// while granted, suspending mid-packet when the grant is withdrawn.
//   clk, rst                          - clock, synchronous active-high reset
//   in_valid/in_ready/in_flit_id/in_data - upstream flit interface
//   req, flit_id, length              - arbiter request, head flit id, packet length
//   grant                             - this port's grant bit from the arbiter
//   out_valid/out_flit_id/out_data    - registered flit towards the crossbar
//   err                               - one-cycle protocol error pulse
// Optional feature: define PORT_REQ_LEN_CHECK_EN to enable the per-packet
// sent-flit counter and error reporting; otherwise err is tied low.
module port_requester
  import router_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_flit_id,
  input  logic [DATA_W-1:0] in_data,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [LEN_W-1:0]  length,
  input  logic              grant,
  output logic              out_valid,
  output logic [2:0]        out_flit_id,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);

  localparam int FW = 3 + DATA_W;

  logic              fifo_full, fifo_empty;
  logic [FW-1:0]     head;
  logic [2:0]        head_id;
  logic [DATA_W-1:0] head_data;
  logic              pop_send, pop_drop, pop;

  req_state_e        state_q, state_d;
  logic [LEN_W-1:0]  length_q, length_d;
  logic              out_valid_q;
  logic [2:0]        out_flit_id_q;
  logic [DATA_W-1:0] out_data_q;

  flit_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (in_valid),
    .wdata_i({in_flit_id, in_data}),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  assign {head_id, head_data} = head;
  assign pop = pop_send | pop_drop;

  // A full FIFO still accepts a flit in a cycle that pops one.
  assign in_ready = !fifo_full || pop;
  assign flit_id  = fifo_empty ? 3'b000 : head_id;
  assign req      = (state_q != IDLE);
  assign length   = length_q;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    pop_send = 1'b0;
    pop_drop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (head_id == HEADER) begin
            length_d = head_data[LEN_W-1:0];
            state_d  = REQ;
          end else begin
            pop_drop = 1'b1;  // orphan flit outside a packet
          end
        end
      end
      REQ: begin
        if (grant) state_d = SEND;
      end
      SEND: begin
        if (!grant) begin
          state_d = SUSPEND;  // arbiter timeout: hold req, resume on re-grant
        end else if (!fifo_empty) begin
          pop_send = 1'b1;
          if (head_id == TAIL) state_d = IDLE;
        end
      end
      SUSPEND: begin
        if (grant) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      length_q      <= '0;
      out_valid_q   <= 1'b0;
      out_flit_id_q <= '0;
      out_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      out_valid_q <= pop_send;
      if (pop_send) begin
        out_flit_id_q <= head_id;
        out_data_q    <= head_data;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_flit_id = out_flit_id_q;
  assign out_data    = out_data_q;

`ifdef PORT_REQ_LEN_CHECK_EN
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_next;
  logic             err_q, err_d;

  // Count flits sent in the current packet; errors only flag, never alter flow.
  always_comb begin
    cnt_d    = cnt_q;
    err_d    = pop_drop;
    cnt_next = cnt_q + LEN_W'(1);
    if (state_q == IDLE) cnt_d = '0;
    if (pop_send) begin
      cnt_d = cnt_next;
      if (head_id == TAIL) begin
        if (cnt_next != length_q) err_d = 1'b1;
      end else if (cnt_next == length_q) begin
        err_d = 1'b1;  // length reached without a tail
      end
      // Only the packet's own header may pop with a zero count.
      if (head_id == HEADER && cnt_q != '0) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
